// File: rtl/fwd_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_pkg
// Shared types for the forwarding/scoreboard unit:
//   Gr       - architectural register number (32 GPRs)
//   DType    - datapath word
//   FwdStage - one forwarding stage as seen at the ID/EX boundary
//   reg_bit  - one-hot mask for a register number
// -----------------------------------------------------------------------------
package fwd_scoreboard_pkg;

    localparam int GR_W     = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef logic [GR_W-1:0]   Gr;
    typedef logic [DATA_W-1:0] DType;

    // ready=0 means the stage holds a register-writing instruction whose
    // result is not final yet (a load still in MEM).
    typedef struct packed {
        logic valid;
        Gr    no;
        DType data;
        logic ready;
    } FwdStage;

    function automatic logic [NUM_REGS-1:0] reg_bit(input Gr r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_if
// Bundle between the pipeline (master) and the forwarding/scoreboard unit
// (slave).
//   master drives : src_no, src_rf, fwd[], issue_*, complete_*, flush
//   slave drives  : src_data, stall, busy_vec, outstanding, sb_err,
//                   stall_cycles
// -----------------------------------------------------------------------------
interface fwd_scoreboard_if #(
    parameter int NUM_SRC    = 6,
    parameter int NUM_FWD    = 2,
    parameter int LONG_SLOTS = 4
);
    import fwd_scoreboard_pkg::*;

    localparam int CNT_W = $clog2(LONG_SLOTS + 1);

    // operand resolution
    Gr       [NUM_SRC-1:0] src_no;
    DType    [NUM_SRC-1:0] src_rf;
    DType    [NUM_SRC-1:0] src_data;
    FwdStage [NUM_FWD-1:0] fwd;        // index 0 = youngest (MEM)

    // scoreboard events
    logic                  issue_valid;
    logic                  issue_long;
    Gr                     issue_rd;
    logic                  complete_valid;
    Gr                     complete_rd;
    logic                  flush;

    // status
    logic                  stall;
    logic [31:0]           busy_vec;
    logic [CNT_W-1:0]      outstanding;
    logic                  sb_err;
    logic [31:0]           stall_cycles;

    modport master (
        output src_no, src_rf, fwd,
        output issue_valid, issue_long, issue_rd,
        output complete_valid, complete_rd, flush,
        input  src_data, stall, busy_vec, outstanding, sb_err, stall_cycles
    );

    modport slave (
        input  src_no, src_rf, fwd,
        input  issue_valid, issue_long, issue_rd,
        input  complete_valid, complete_rd, flush,
        output src_data, stall, busy_vec, outstanding, sb_err, stall_cycles
    );

endinterface

// File: rtl/fwd_scoreboard_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Tracks registers with an outstanding long-latency write.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_issue_set        accepted long issue to a nonzero register
//   i_issue_rd         its destination
//   i_complete_valid   long result written back this cycle
//   i_complete_rd      its destination
//   i_flush            drop every outstanding long op
//   o_busy_vec         per-register pending bits
//   o_outstanding      number of pending long ops
//   o_sb_err           sticky: completion for a register that was not busy
// -----------------------------------------------------------------------------
module reg_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int LONG_SLOTS = 4,
    parameter int CNT_W      = $clog2(LONG_SLOTS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_issue_set,
    input  Gr                   i_issue_rd,
    input  logic                i_complete_valid,
    input  Gr                   i_complete_rd,
    input  logic                i_flush,
    output logic [NUM_REGS-1:0] o_busy_vec,
    output logic [CNT_W-1:0]    o_outstanding,
    output logic                o_sb_err
);

    logic [NUM_REGS-1:0] r_busy_vec;
    logic [CNT_W-1:0]    r_outstanding;
    logic                r_sb_err;

    logic                w_complete_hit;
    logic                w_clr;
    logic                w_err;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    assign w_complete_hit = r_busy_vec[i_complete_rd];
    assign w_clr          = i_complete_valid && w_complete_hit;
    assign w_err          = i_complete_valid && !w_complete_hit;
    assign w_set_mask     = i_issue_set ? reg_bit(i_issue_rd)    : '0;
    assign w_clr_mask     = w_clr       ? reg_bit(i_complete_rd) : '0;

    // An issue to a busy register is always stalled upstream, so the set and
    // clear masks never name the same busy register in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_vec    <= '0;
            r_outstanding <= '0;
            r_sb_err      <= 1'b0;
        end else if (i_flush) begin
            // Flush wins over issue/complete; the error flag survives it.
            r_busy_vec    <= '0;
            r_outstanding <= '0;
        end else begin
            r_busy_vec    <= (r_busy_vec & ~w_clr_mask) | w_set_mask;
            r_outstanding <= r_outstanding + CNT_W'(i_issue_set) - CNT_W'(w_clr);
            if (w_err) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    assign o_busy_vec    = r_busy_vec;
    assign o_outstanding = r_outstanding;
    assign o_sb_err      = r_sb_err;

endmodule

// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
// Operand bypass resolution for NUM_SRC sources over NUM_FWD forwarding stages
// (youngest-first), plus the long-latency register scoreboard and the ID
// stall it implies.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus         fwd_scoreboard_if.slave (operands, stages, issue/complete,
//               flush in; src_data, stall, busy_vec, outstanding, sb_err,
//               stall_cycles out)
// Resolution and stall are combinational; scoreboard state updates on the
// next edge.
// -----------------------------------------------------------------------------
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int NUM_SRC    = 6,
    parameter int NUM_FWD    = 2,
    parameter int LONG_SLOTS = 4
) (
    input logic             clk,
    input logic             reset,
    fwd_scoreboard_if.slave bus
);

    localparam int CNT_W = $clog2(LONG_SLOTS + 1);

    logic [NUM_REGS-1:0] w_busy_vec;
    logic [CNT_W-1:0]    w_outstanding;
    logic                w_sb_err;

    logic [NUM_SRC-1:0]  w_wait_fwd;
    logic [NUM_SRC-1:0]  w_wait_busy;
    logic                w_wait_issue;
    logic                w_stall;
    logic                w_issue_set;

    logic [31:0]         r_stall_cycles;

    // ---------------------------------------------------------------------
    // Per-source bypass selection
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [NUM_FWD-1:0] w_hit;
        DType               w_fwd_sel;
        logic               w_rdy_sel;
        logic               w_nz;

        for (genvar gj = 0; gj < NUM_FWD; gj++) begin : g_stage
            assign w_hit[gj] = bus.fwd[gj].valid && (bus.fwd[gj].no == bus.src_no[gi]);
        end

        assign w_nz = (bus.src_no[gi] != '0);

        // Walk oldest to youngest so the youngest matching stage wins. Only
        // that stage's ready bit matters: a stale older copy is never used.
        always_comb begin
            w_fwd_sel = bus.src_rf[gi];
            w_rdy_sel = 1'b1;
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (w_hit[j]) begin
                    w_fwd_sel = bus.fwd[j].data;
                    w_rdy_sel = bus.fwd[j].ready;
                end
            end
        end

        assign bus.src_data[gi] = w_nz ? w_fwd_sel : '0;
        assign w_wait_fwd[gi]   = w_nz && (|w_hit) && !w_rdy_sel;

        // A completing long op is on a forwarding stage this cycle, so the
        // busy bit need not stall a reader of that register.
        assign w_wait_busy[gi]  = w_nz && w_busy_vec[bus.src_no[gi]] &&
                                  !(bus.complete_valid && (bus.complete_rd == bus.src_no[gi]));
    end

    // WAW on a pending register, or no free long slot.
    assign w_wait_issue = bus.issue_valid && bus.issue_long &&
                          (w_busy_vec[bus.issue_rd] || (w_outstanding == CNT_W'(LONG_SLOTS)));

    assign w_stall     = (|w_wait_fwd) || (|w_wait_busy) || w_wait_issue;

    // r0 is never tracked: a long write to it has no architectural effect.
    assign w_issue_set = bus.issue_valid && !w_stall && !bus.flush &&
                         bus.issue_long && (bus.issue_rd != '0);

    // ---------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------
    reg_scoreboard #(
        .LONG_SLOTS (LONG_SLOTS),
        .CNT_W      (CNT_W)
    ) u_reg_scoreboard (
        .clk              (clk),
        .reset            (reset),
        .i_issue_set      (w_issue_set),
        .i_issue_rd       (bus.issue_rd),
        .i_complete_valid (bus.complete_valid),
        .i_complete_rd    (bus.complete_rd),
        .i_flush          (bus.flush),
        .o_busy_vec       (w_busy_vec),
        .o_outstanding    (w_outstanding),
        .o_sb_err         (w_sb_err)
    );

    // ---------------------------------------------------------------------
    // Saturating stall counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.busy_vec     = w_busy_vec;
    assign bus.outstanding  = w_outstanding;
    assign bus.sb_err       = w_sb_err;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
